// File: rtl/sseg_pkg.sv
// sseg_pkg: shared definitions for the seven-segment scan driver.
//   - SEG_HEX    : 16-entry active-high segment patterns {g,f,e,d,c,b,a} for 0..F
//   - SEG_DASH   : segment g only, shown on overflow
//   - SEG_BLANK  : all segments off
//   - state_t    : convert FSM states (IDLE, SHIFT, UPDATE)
//   - seg_pol()  : applies the board's segment polarity to an active-high pattern
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Index 15 is listed first so SEG_HEX[n] is the pattern for nibble n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    function automatic logic [6:0] seg_pol(input logic [6:0] s, input logic active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
//   clk, rst : clock, synchronous active-high reset
//   start    : load bin and clear the BCD accumulator (takes priority)
//   bin      : binary value sampled on start
//   done     : high during the last shift cycle; bcd is final on the next cycle
//   bcd      : NIBBLES BCD digits, nibble 0 least significant
//   carry    : a set bit was shifted out of the top nibble (value too large)
// One shift per cycle, WIDTH cycles after start.
module bin2bcd_seq #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       bin,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   bcd,
    output logic                   carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]     sr;
    logic [CW-1:0]        cnt;
    logic                 busy;
    logic [4*NIBBLES-1:0] adj;

    // Add-3 correction on every nibble >= 5 ahead of the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NIBBLES; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign done = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            carry <= 1'b0;
        end else if (start) begin
            sr    <= bin;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            carry <= 1'b0;
        end else if (busy) begin
            bcd   <= {adj[4*NIBBLES-2:0], sr[WIDTH-1]};
            sr    <= {sr[WIDTH-2:0], 1'b0};
            // Anything leaving the top nibble means the value exceeds NIBBLES digits.
            carry <= carry | adj[4*NIBBLES-1];
            cnt   <= cnt + CW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: multiplexed seven-segment display driver.
//   clk, rst : clock, synchronous active-high reset
//   num      : binary value to display
//   hex_mode : 1 = hex nibbles, 0 = decimal
//   sseg     : segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//   an       : one-hot digit enable, polarity per ACTIVE_LOW
//   ovf      : value does not fit in DIGITS digits (digits show dashes)
//   upd      : one-cycle pulse when the digit register is refreshed
// A free-running IDLE/SHIFT/UPDATE loop (WIDTH+2 cycles) samples num and
// refreshes the digit register; the scan runs independently of that loop.
// Build option SSEG_LZB_EN: leading-zero blanking in decimal mode.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  num,
    input  logic              hex_mode,
    output logic [6:0]        sseg,
    output logic [DIGITS-1:0] an,
    output logic              ovf,
    output logic              upd
);

    localparam int   NIB  = DIGITS + 1;
    localparam int   IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int   CNTW = $clog2(REFRESH_DIV);
    localparam int   HB   = 4 * DIGITS;
    localparam int   HX   = (WIDTH > HB) ? WIDTH : HB;
    localparam logic POL  = (ACTIVE_LOW != 0);

    // ---------------- convert FSM ----------------
    state_t state, state_nxt;
    logic   start, load, done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = SHIFT;
            SHIFT:   if (done) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start = (state == IDLE);
        load  = (state == UPDATE);
    end

    // Shadow copies: num/hex_mode are only looked at in IDLE.
    logic [WIDTH-1:0] num_sh;
    logic             hex_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            num_sh <= '0;
            hex_sh <= 1'b0;
        end else if (start) begin
            num_sh <= num;
            hex_sh <= hex_mode;
        end
    end

    logic [4*NIB-1:0] bcd;
    logic             carry;

    bin2bcd_seq #(
        .WIDTH   (WIDTH),
        .NIBBLES (NIB)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (num),
        .done  (done),
        .bcd   (bcd),
        .carry (carry)
    );

    // ---------------- digit decode ----------------
    logic [HX-1:0]            num_ext;
    logic                     dec_ovf, hex_ovf, ovf_new;
    logic [3:0]               nib;
    logic [DIGITS-1:0][6:0]   seg_new;
`ifdef SSEG_LZB_EN
    logic                     lead;
`endif

    always_comb begin
        num_ext = HX'(num_sh);  // missing upper hex nibbles read as 0
        dec_ovf = carry | (bcd[4*DIGITS +: 4] != 4'd0);
        hex_ovf = |(num_ext >> HB);
        ovf_new = hex_sh ? hex_ovf : dec_ovf;
        nib     = '0;
        seg_new = '0;
`ifdef SSEG_LZB_EN
        lead    = 1'b1;
`endif
        // Walk from the most significant digit so leading zeros can be tracked.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = hex_sh ? num_ext[4*k +: 4] : bcd[4*k +: 4];
            seg_new[k] = ovf_new ? SEG_DASH : SEG_HEX[nib];
`ifdef SSEG_LZB_EN
            if (nib != 4'd0)
                lead = 1'b0;
            if (!hex_sh && !ovf_new && lead && (k != 0))
                seg_new[k] = SEG_BLANK;
`endif
        end
    end

    // ---------------- scan + registered outputs ----------------
    logic [CNTW-1:0]        cnt, cnt_nxt;
    logic [IDXW-1:0]        idx, idx_nxt;
    logic [DIGITS-1:0][6:0] digit_q, digit_nxt;
    logic                   disp_q, disp_nxt;
    logic [DIGITS-1:0]      an_nxt;
    logic                   tc;

    always_comb begin
        tc        = (cnt == CNTW'(REFRESH_DIV - 1));
        cnt_nxt   = tc ? '0 : cnt + CNTW'(1);
        idx_nxt   = idx;
        if (tc)
            idx_nxt = (idx == IDXW'(DIGITS - 1)) ? '0 : idx + IDXW'(1);
        digit_nxt = load ? seg_new : digit_q;
        // Digits stay dark until the first conversion lands after reset.
        disp_nxt  = disp_q | load;
        an_nxt    = disp_nxt ? (DIGITS'(1) << idx_nxt) : '0;
    end

    // sseg/an are both registered from next-state values so they switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            digit_q <= '0;
            disp_q  <= 1'b0;
            ovf     <= 1'b0;
            upd     <= 1'b0;
            sseg    <= seg_pol(SEG_BLANK, POL);
            an      <= POL ? '1 : '0;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            digit_q <= digit_nxt;
            disp_q  <= disp_nxt;
            upd     <= load;
            if (load)
                ovf <= ovf_new;
            sseg    <= seg_pol(disp_nxt ? digit_nxt[idx_nxt] : SEG_BLANK, POL);
            an      <= POL ? ~an_nxt : an_nxt;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 16;
    localparam int RDIV   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] num = 16'd4321;
    logic        hex_mode = 1'b0;
    logic [6:0]  sseg;
    logic [3:0]  an;
    logic        ovf, upd;

    sseg_scan_driver #(
        .DIGITS(DIGITS), .WIDTH(WIDTH), .REFRESH_DIV(RDIV), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .num(num), .hex_mode(hex_mode),
        .sseg(sseg), .an(an), .ovf(ovf), .upd(upd)
    );

    always #5 clk = ~clk;

    // Active-low segment patterns, hand-inverted from the segment map.
    localparam logic [6:0] L0   = 7'b1000000;
    localparam logic [6:0] L1   = 7'b1111001;
    localparam logic [6:0] L2   = 7'b0100100;
    localparam logic [6:0] L3   = 7'b0110000;
    localparam logic [6:0] L4   = 7'b0011001;
    localparam logic [6:0] L7   = 7'b1111000;
    localparam logic [6:0] L9   = 7'b0010000;
    localparam logic [6:0] LE   = 7'b0000110;
    localparam logic [6:0] LF   = 7'b0001110;
    localparam logic [6:0] LHB  = 7'b0000011;
    localparam logic [6:0] LDSH = 7'b0111111;
    localparam logic [6:0] LBLK = 7'b1111111;
`ifdef SSEG_LZB_EN
    localparam logic [6:0] LZ   = LBLK;
`else
    localparam logic [6:0] LZ   = L0;
`endif

    typedef struct packed {
        logic [15:0]      tag;
        logic             ovf;
        logic [3:0][6:0]  seg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames = 0;

    function automatic exp_t mk(input logic [15:0] tag, input logic o,
                                input logic [6:0] d3, d2, d1, d0);
        exp_t e;
        e.tag = tag; e.ovf = o; e.seg = {d3, d2, d1, d0};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: on each upd with an expectation queued, watch one full scan.
    exp_t       mon_e;
    logic [3:0] mon_seen;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (upd && q.size() > 0) begin
                mon_e    = q.pop_front();
                mon_seen = '0;
                chk($sformatf("ovf num=%0h", mon_e.tag), {31'd0, ovf}, {31'd0, mon_e.ovf});
                for (int c = 0; c < DIGITS * RDIV; c++) begin
                    if (c > 0) begin @(posedge clk); #1; end
                    if ($onehot(~an)) begin
                        for (int k = 0; k < DIGITS; k++) begin
                            if (!an[k]) begin
                                mon_seen[k] = 1'b1;
                                chk($sformatf("seg num=%0h digit %0d", mon_e.tag, k),
                                    {25'd0, sseg}, {25'd0, mon_e.seg[k]});
                            end
                        end
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL an_onehot num=%0h: got %b expected one low bit", mon_e.tag, an);
                    end
                end
                chk($sformatf("scan_cover num=%0h", mon_e.tag), {28'd0, mon_seen}, 32'hF);
                frames++;
            end
        end
    end

    task automatic wait_upd(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (upd) begin got = 1'b1; break; end
        end
        if (!got) fail_now("wait_upd");
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 120 && frames < target; i++) @(negedge clk);
        if (frames < target) fail_now("frame_check");
    endtask

    // Change inputs in the IDLE cycle right after upd, so the next upd shows them.
    task automatic apply(input logic [15:0] n, input logic h, input exp_t e);
        bit got;
        int f0;
        f0 = frames;
        wait_upd(got);
        if (got) begin
            num = n; hex_mode = h;
            q.push_back(e);
            wait_frames(f0 + 1);
        end
    endtask

    // Reset edge: outputs dark, then upd exactly one full loop later with an dark throughout.
    task automatic reset_and_time(input string name);
        int  n;
        bit  dark;
        rst = 1'b1;
        @(posedge clk); #1;
        chk({name, "_an"},   {28'd0, an},   32'hF);
        chk({name, "_sseg"}, {25'd0, sseg}, 32'h7F);
        chk({name, "_ovf"},  {31'd0, ovf},  32'd0);
        chk({name, "_upd"},  {31'd0, upd},  32'd0);
        @(negedge clk);
        rst  = 1'b0;
        n    = 0;
        dark = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            n = i;
            if (upd) break;
            if (an !== 4'hF) dark = 1'b0;
        end
        chk({name, "_latency"}, n, WIDTH + 2);
        chk({name, "_dark"}, {31'd0, dark}, 32'd1);
    endtask

    initial begin
        bit got;
        int f0;

        // Power-up reset with 4321 decimal already on num.
        q.push_back(mk(16'd4321, 1'b0, L4, L3, L2, L1));
        f0 = frames;
        reset_and_time("por");
        wait_frames(f0 + 1);

        apply(16'd12345, 1'b0, mk(16'd12345, 1'b1, LDSH, LDSH, LDSH, LDSH));
        apply(16'hBEEF,  1'b1, mk(16'hBEEF,  1'b0, LHB, LE, LE, LF));
        apply(16'h0007,  1'b1, mk(16'h0007,  1'b0, L0, L0, L0, L7));
        apply(16'd7,     1'b0, mk(16'd7,     1'b0, LZ, LZ, LZ, L7));
        apply(16'd0,     1'b0, mk(16'd0,     1'b0, LZ, LZ, LZ, L0));
        apply(16'd9999,  1'b0, mk(16'd9999,  1'b0, L9, L9, L9, L9));
        apply(16'd10000, 1'b0, mk(16'd10000, 1'b1, LDSH, LDSH, LDSH, LDSH));

        // 4321 captured, then 9999 arrives during SHIFT: seen only a loop later.
        f0 = frames;
        wait_upd(got);
        if (got) begin
            num = 16'd4321; hex_mode = 1'b0;
            q.push_back(mk(16'd4321, 1'b0, L4, L3, L2, L1));
            repeat (6) @(negedge clk);
            num = 16'd9999;
            q.push_back(mk(16'd9999, 1'b0, L9, L9, L9, L9));
            wait_frames(f0 + 2);
        end

        // Reset in the middle of SHIFT discards the conversion.
        wait_upd(got);
        if (got) begin
            repeat (5) @(negedge clk);
            q.push_back(mk(16'd9999, 1'b0, L9, L9, L9, L9));
            f0 = frames;
            reset_and_time("midrst");
            wait_frames(f0 + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
